// File: rtl/vga_trace_drawer_if.sv
// Pixel write channel from the trace drawer toward the frame-buffer writer.
interface vga_trace_drawer_if #(
    parameter int X_BITS  = 8,
    parameter int Y_BITS  = 7,
    parameter int COLOR_W = 12
);
    logic               pix_valid;
    logic               pix_ready;
    logic [X_BITS-1:0]  pix_x;
    logic [Y_BITS-1:0]  pix_y;
    logic [COLOR_W-1:0] pix_color;

    modport master (output pix_valid, pix_x, pix_y, pix_color, input pix_ready);
    modport slave  (input pix_valid, pix_x, pix_y, pix_color, output pix_ready);
endinterface

// File: rtl/vga_trace_drawer.sv
// Multi-channel column sweeper: fetches one sample per column per enabled channel
// and emits dot or vertical-line pixels over a valid/ready channel.
module vga_trace_drawer #(
    parameter int X_BITS  = 8,
    parameter int N_COLS  = 160,
    parameter int Y_BITS  = 7,
    parameter int N_ROWS  = 120,
    parameter int N_CH    = 2,
    parameter int COLOR_W = 12,
    parameter logic [N_CH*COLOR_W-1:0] CH_COLORS = {12'hF00, 12'h0F0},
    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                mode,
    input  logic [N_CH-1:0]     ch_enable,
    output logic                busy,
    output logic                done,
    output logic                rd_en,
    output logic [CH_W-1:0]     rd_ch,
    output logic [X_BITS-1:0]   rd_addr,
    input  logic [Y_BITS-1:0]   rd_data,
    vga_trace_drawer_if.master  pix
);
    localparam logic [Y_BITS-1:0] Y_MAX  = Y_BITS'(N_ROWS - 1);
    localparam logic [X_BITS-1:0] X_LAST = X_BITS'(N_COLS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SEL, S_FETCH, S_WAIT, S_DRAW, S_NEXT, S_DONE
    } state_t;

    state_t             state;
    logic               mode_r;
    logic [N_CH-1:0]    remaining;
    logic [Y_BITS-1:0]  prev_y;
    logic [Y_BITS-1:0]  span_hi;

    logic               any_left;
    logic [CH_W-1:0]    next_ch;
    logic [Y_BITS-1:0]  sample;
    logic [Y_BITS-1:0]  span_lo_c;
    logic [Y_BITS-1:0]  span_hi_c;

    always_comb begin
        any_left = 1'b0;
        next_ch  = '0;
        for (int unsigned i = N_CH; i > 0; i--) begin
            if (remaining[i-1]) begin
                any_left = 1'b1;
                next_ch  = CH_W'(i - 1);
            end
        end
    end

    always_comb begin
        sample    = (rd_data > Y_MAX) ? Y_MAX : rd_data;
        span_lo_c = sample;
        span_hi_c = sample;
        // Column 0 never joins to prev_y, so a stale value from another channel is harmless.
        if (mode_r && (rd_addr != '0)) begin
            span_lo_c = (prev_y < sample) ? prev_y : sample;
            span_hi_c = (prev_y < sample) ? sample : prev_y;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            rd_en         <= 1'b0;
            rd_ch         <= '0;
            rd_addr       <= '0;
            mode_r        <= 1'b0;
            remaining     <= '0;
            prev_y        <= '0;
            span_hi       <= '0;
            pix.pix_valid <= 1'b0;
            pix.pix_x     <= '0;
            pix.pix_y     <= '0;
            pix.pix_color <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        mode_r    <= mode;
                        remaining <= ch_enable;
                        busy      <= 1'b1;
                        state     <= S_SEL;
                    end
                end
                S_SEL: begin
                    if (any_left) begin
                        remaining[next_ch] <= 1'b0;
                        rd_ch   <= next_ch;
                        rd_addr <= '0;
                        rd_en   <= 1'b1;
                        state   <= S_FETCH;
                    end else begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_FETCH: begin
                    rd_en <= 1'b0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    prev_y        <= sample;
                    span_hi       <= span_hi_c;
                    pix.pix_valid <= 1'b1;
                    pix.pix_x     <= rd_addr;
                    pix.pix_y     <= span_lo_c;
                    pix.pix_color <= CH_COLORS[int'(rd_ch)*COLOR_W +: COLOR_W];
                    state         <= S_DRAW;
                end
                S_DRAW: begin
                    if (pix.pix_ready) begin
                        if (pix.pix_y == span_hi) begin
                            pix.pix_valid <= 1'b0;
                            state         <= S_NEXT;
                        end else begin
                            pix.pix_y <= pix.pix_y + 1'b1;
                        end
                    end
                end
                S_NEXT: begin
                    if (rd_addr == X_LAST) begin
                        rd_addr <= '0;
                        state   <= S_SEL;
                    end else begin
                        rd_addr <= rd_addr + 1'b1;
                        rd_en   <= 1'b1;
                        state   <= S_FETCH;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
